// File: rtl/hls_handshake_profiler.sv
// Per-channel HLS ap_ctrl handshake profiler (txn/latency/busy/stall, optional interval stats via HLS_PROF_II_EN).
// Latency: statistics reflect a handshake the cycle after it; read data appears one cycle after rd_en.
// Backpressure: none; passively taps handshakes and accepts a read every cycle.
module hls_handshake_profiler #(
    parameter int NCH   = 7,
    parameter int CNT_W = 32,
    parameter int CH_W  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NCH-1:0]   ap_start,
    input  logic [NCH-1:0]   ap_ready,
    input  logic [NCH-1:0]   ap_done,
    input  logic [NCH-1:0]   ap_continue,
    input  logic             finish,
    input  logic             clear,
    input  logic             rd_en,
    input  logic [CH_W-1:0]  rd_ch,
    input  logic [2:0]       rd_field,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   overflow,
    output logic             frozen
);
    localparam logic [CNT_W-1:0] MAXV = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_WAIT = 2'd2} state_t;

    state_t           state_q [NCH];
    state_t           state_d [NCH];
    logic [NCH-1:0]   start_fire, commit, in_run, in_wait, ovf_ev, ii_ovf;
    logic [CNT_W-1:0] lat_now   [NCH];
    logic [CNT_W-1:0] lat_q     [NCH];
    logic [CNT_W-1:0] txn_cnt   [NCH];
    logic [CNT_W-1:0] last_lat  [NCH];
    logic [CNT_W-1:0] min_lat   [NCH];
    logic [CNT_W-1:0] max_lat   [NCH];
    logic [CNT_W-1:0] busy_cyc  [NCH];
    logic [CNT_W-1:0] stall_cyc [NCH];
    logic [CNT_W-1:0] rd_mux;
    logic             stat_en;

`ifdef HLS_PROF_II_EN
    logic [CNT_W-1:0] ii_cnt  [NCH];
    logic [CNT_W-1:0] last_ii [NCH];
    logic [CNT_W-1:0] min_ii  [NCH];
    logic [NCH-1:0]   ii_arm, ii_seen;
`else
    logic unused_ready;
    assign unused_ready = ^ap_ready;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == MAXV) ? MAXV : x + ONE;
    endfunction

    function automatic logic near_max(input logic [CNT_W-1:0] x);
        return x >= (MAXV - ONE);
    endfunction

    // The finish cycle itself is already excluded from the statistics.
    assign stat_en = !(frozen || finish);

    always_ff @(posedge clock) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (reset || clear) state_q[ch] <= ST_IDLE;
            else                state_q[ch] <= state_d[ch];
        end
    end

    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            state_d[ch] = state_q[ch];
            case (state_q[ch])
                ST_IDLE: if (ap_start[ch]) begin
                    if (ap_done[ch]) state_d[ch] = ap_continue[ch] ? ST_IDLE : ST_WAIT;
                    else             state_d[ch] = ST_RUN;
                end
                ST_RUN:  if (ap_done[ch]) state_d[ch] = ap_continue[ch] ? ST_IDLE : ST_WAIT;
                ST_WAIT: if (ap_continue[ch]) state_d[ch] = ST_IDLE;
                default: state_d[ch] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            in_run[ch]     = (state_q[ch] == ST_RUN);
            in_wait[ch]    = (state_q[ch] == ST_WAIT);
            start_fire[ch] = (state_q[ch] == ST_IDLE) && ap_start[ch];
            commit[ch]     = ap_done[ch] && (start_fire[ch] || in_run[ch]);
            lat_now[ch]    = in_run[ch] ? sat_inc(lat_q[ch]) : ONE;
            busy[ch]       = in_run[ch] || in_wait[ch];
`ifdef HLS_PROF_II_EN
            ii_ovf[ch]     = ii_arm[ch] && !ap_ready[ch] && near_max(ii_cnt[ch]);
`else
            ii_ovf[ch]     = 1'b0;
`endif
            ovf_ev[ch]     = (commit[ch] && near_max(txn_cnt[ch]))
                          || ((start_fire[ch] || busy[ch]) && near_max(busy_cyc[ch]))
                          || (in_wait[ch] && near_max(stall_cyc[ch]))
                          || (in_run[ch] && near_max(lat_q[ch]))
                          || ii_ovf[ch];
        end
    end

    always_ff @(posedge clock) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (reset || clear) begin
                lat_q[ch]     <= '0;
                txn_cnt[ch]   <= '0;
                last_lat[ch]  <= '0;
                min_lat[ch]   <= MAXV;
                max_lat[ch]   <= '0;
                busy_cyc[ch]  <= '0;
                stall_cyc[ch] <= '0;
                overflow[ch]  <= 1'b0;
`ifdef HLS_PROF_II_EN
                ii_cnt[ch]    <= '0;
                last_ii[ch]   <= '0;
                min_ii[ch]    <= MAXV;
                ii_arm[ch]    <= 1'b0;
                ii_seen[ch]   <= 1'b0;
`endif
            end else begin
                // Trackers keep following the handshakes while frozen; only statistics are held.
                if (start_fire[ch])  lat_q[ch] <= ONE;
                else if (in_run[ch]) lat_q[ch] <= sat_inc(lat_q[ch]);
                if (stat_en) begin
                    if (commit[ch]) begin
                        txn_cnt[ch]  <= sat_inc(txn_cnt[ch]);
                        last_lat[ch] <= lat_now[ch];
                        if (lat_now[ch] < min_lat[ch]) min_lat[ch] <= lat_now[ch];
                        if (lat_now[ch] > max_lat[ch]) max_lat[ch] <= lat_now[ch];
                    end
                    if (start_fire[ch] || busy[ch]) busy_cyc[ch] <= sat_inc(busy_cyc[ch]);
                    if (in_wait[ch]) stall_cyc[ch] <= sat_inc(stall_cyc[ch]);
                    if (ovf_ev[ch])  overflow[ch] <= 1'b1;
                end
`ifdef HLS_PROF_II_EN
                if (ap_ready[ch]) begin
                    ii_arm[ch] <= 1'b1;
                    ii_cnt[ch] <= ONE;
                    if (ii_arm[ch] && stat_en) begin
                        last_ii[ch] <= ii_cnt[ch];
                        if (ii_cnt[ch] < min_ii[ch]) min_ii[ch] <= ii_cnt[ch];
                        ii_seen[ch] <= 1'b1;
                    end
                end else if (ii_arm[ch]) begin
                    ii_cnt[ch] <= sat_inc(ii_cnt[ch]);
                end
`endif
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (int'(rd_ch) < NCH) begin
            case (rd_field)
                3'd0: rd_mux = txn_cnt[rd_ch];
                3'd1: rd_mux = last_lat[rd_ch];
                3'd2: rd_mux = (txn_cnt[rd_ch] == '0) ? '0 : min_lat[rd_ch];
                3'd3: rd_mux = max_lat[rd_ch];
                3'd4: rd_mux = busy_cyc[rd_ch];
                3'd5: rd_mux = stall_cyc[rd_ch];
`ifdef HLS_PROF_II_EN
                3'd6: rd_mux = last_ii[rd_ch];
                3'd7: rd_mux = ii_seen[rd_ch] ? min_ii[rd_ch] : '0;
`endif
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            frozen   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)  rd_data <= rd_mux;
            if (finish) frozen  <= 1'b1;
        end
    end
endmodule
